// File: rtl/sinegen_pkg.sv
// Shared types and constants for the sine ROM read-side address generator.
//   state_t     : controller states (IDLE, RUN, DRAIN)
//   ROM_LATENCY : read latency of the registered dual-port sine ROM
//   DRAIN_DEPTH : in-flight stages between an issued address and its sample
package sinegen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int unsigned ROM_LATENCY = 1;
  localparam int unsigned DRAIN_DEPTH = ROM_LATENCY + 1;

endpackage

// File: rtl/sine_addr_gen_if.sv
// Dual-port sine ROM read bus.
//   addr1/addr2 : port-1/port-2 read addresses (driven by the generator)
//   dout1/dout2 : port-1/port-2 read data (driven by the ROM, 1-cycle registered)
// Modports: master = address generator, slave = ROM.
interface sine_addr_gen_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
);

  logic [ADDRESS_WIDTH-1:0] addr1;
  logic [ADDRESS_WIDTH-1:0] addr2;
  logic [DATA_WIDTH-1:0]    dout1;
  logic [DATA_WIDTH-1:0]    dout2;

  modport master (
    output addr1,
    output addr2,
    input  dout1,
    input  dout2
  );

  modport slave (
    input  addr1,
    input  addr2,
    output dout1,
    output dout2
  );

endinterface

// File: rtl/phase_accum.sv
// Phase accumulator with synchronous clear and step-enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : load zero (wins over step)
//   step       : add incr (wraps modulo 2^ACC_WIDTH)
//   incr       : phase step
//   tap        : top TAP_WIDTH bits of the current (pre-step) accumulator
module phase_accum #(
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned TAP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  input  logic [ACC_WIDTH-1:0] incr,
  output logic [TAP_WIDTH-1:0] tap
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = acc_q + incr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign tap = acc_q[ACC_WIDTH-1 -: TAP_WIDTH];

endmodule

// File: rtl/sine_addr_gen.sv
// Read-side master for the dual-port sine ROM. Issues two phase-offset
// address streams from a phase accumulator and captures the returned samples.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start / stop       : begin burst (IDLE only) / abort issue and drain
//   en                 : issue one address per cycle while running
//   incr, offset       : phase step and ch2 address offset (used live)
//   burst_len          : issues per burst, sampled at start (0 = continuous)
//   rom                : ROM bus (addr1/addr2 out, dout1/dout2 in)
//   sample1/2, valid   : captured samples, valid pulses once per issued address
//   busy, done         : not idle / 1-cycle pulse when a burst fully drains
module sine_addr_gen
  import sinegen_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACC_WIDTH     = 16,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     en,
  input  logic [ACC_WIDTH-1:0]     incr,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  input  logic [CNT_WIDTH-1:0]     burst_len,
  sine_addr_gen_if.master          rom,
  output logic [DATA_WIDTH-1:0]    sample1,
  output logic [DATA_WIDTH-1:0]    sample2,
  output logic                     valid,
  output logic                     busy,
  output logic                     done
);

  state_t                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;
  logic [CNT_WIDTH-1:0]     burst_q, burst_d;
  logic [ADDRESS_WIDTH-1:0] addr1_q, addr1_d;
  logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
  logic [DATA_WIDTH-1:0]    sample1_q, sample1_d;
  logic [DATA_WIDTH-1:0]    sample2_q, sample2_d;
  // pipe_q[0] = address issued last cycle, pipe_q[top] = ROM data ready now
  logic [DRAIN_DEPTH-1:0]   pipe_q, pipe_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;

  logic                     issue;
  logic                     acc_clear;
  logic [ADDRESS_WIDTH-1:0] phase_tap;

  phase_accum #(
    .ACC_WIDTH (ACC_WIDTH),
    .TAP_WIDTH (ADDRESS_WIDTH)
  ) u_phase_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (acc_clear),
    .step  (issue),
    .incr  (incr),
    .tap   (phase_tap)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    burst_d   = burst_q;
    addr1_d   = addr1_q;
    addr2_d   = addr2_q;
    issue     = 1'b0;
    acc_clear = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d   = RUN;
          acc_clear = 1'b1;
          count_d   = '0;
          burst_d   = burst_len;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (en) begin
          issue   = 1'b1;
          addr1_d = phase_tap;
          addr2_d = phase_tap + offset;
          count_d = count_q + CNT_WIDTH'(1);
          if ((burst_q != '0) && (count_q == burst_q - CNT_WIDTH'(1))) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pipe_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pipe_d    = {pipe_q[DRAIN_DEPTH-2:0], issue};
    valid_d   = pipe_q[DRAIN_DEPTH-1];
    sample1_d = valid_d ? rom.dout1 : sample1_q;
    sample2_d = valid_d ? rom.dout2 : sample2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      burst_q   <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      sample1_q <= '0;
      sample2_q <= '0;
      pipe_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      burst_q   <= burst_d;
      addr1_q   <= addr1_d;
      addr2_q   <= addr2_d;
      sample1_q <= sample1_d;
      sample2_q <= sample2_d;
      pipe_q    <= pipe_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign rom.addr1 = addr1_q;
  assign rom.addr2 = addr2_q;
  assign sample1   = sample1_q;
  assign sample2   = sample2_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sine_addr_gen.sv
// Bench for sine_addr_gen paired with a 1-cycle registered dual-port ROM model.
// A behavioural model tracks phase, issued addresses and the two-edge sample
// delivery; a negedge process compares every output against it each cycle.
module tb_sine_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        en = 1'b0;
  logic [15:0] incr = '0;
  logic [7:0]  offset = '0;
  logic [15:0] burst_len = '0;
  logic [7:0]  sample1, sample2;
  logic        valid, busy, done;

  sine_addr_gen_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) rom_bus ();

  sine_addr_gen #(
    .ADDRESS_WIDTH (8),
    .DATA_WIDTH    (8),
    .ACC_WIDTH     (16),
    .CNT_WIDTH     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .en        (en),
    .incr      (incr),
    .offset    (offset),
    .burst_len (burst_len),
    .rom       (rom_bus),
    .sample1   (sample1),
    .sample2   (sample2),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ROM contents: rom[a] = (37*a + 11) mod 256
  logic [7:0] rom [256];
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 11) % 256);
  end

  always @(posedge clk) begin
    rom_bus.dout1 <= rom[rom_bus.addr1];
    rom_bus.dout2 <= rom[rom_bus.addr2];
  end

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 running, 2 draining
  int unsigned m_mode = 0;
  logic [15:0] m_phase = '0;
  int unsigned m_issued = 0;
  int unsigned m_total = 0;
  logic [7:0]  m_a1 = '0, m_a2 = '0, m_s1 = '0, m_s2 = '0;
  logic        m_valid = 1'b0, m_done = 1'b0;
  // h1: issue at the previous edge, h2: issue two edges back
  logic        h1_v = 1'b0, h2_v = 1'b0;
  logic [7:0]  h1_a1 = '0, h1_a2 = '0, h2_a1 = '0, h2_a2 = '0;
  logic [7:0]  t_a1, t_a2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode   <= 0;
      m_phase  <= '0;
      m_issued <= 0;
      m_total  <= 0;
      m_a1     <= '0;
      m_a2     <= '0;
      m_s1     <= '0;
      m_s2     <= '0;
      m_valid  <= 1'b0;
      m_done   <= 1'b0;
      h1_v     <= 1'b0;
      h2_v     <= 1'b0;
    end else begin
      m_valid <= h2_v;
      if (h2_v) begin
        m_s1 <= rom[h2_a1];
        m_s2 <= rom[h2_a2];
      end
      h2_v  <= h1_v;
      h2_a1 <= h1_a1;
      h2_a2 <= h1_a2;
      h1_v  <= 1'b0;
      m_done <= 1'b0;
      case (m_mode)
        0: if (start && !stop) begin
          m_mode   <= 1;
          m_phase  <= '0;
          m_issued <= 0;
          m_total  <= 32'(burst_len);
        end
        1: if (stop) begin
          m_mode <= 2;
        end else if (en) begin
          t_a1 = m_phase[15:8];
          t_a2 = t_a1 + offset;
          m_a1  <= t_a1;
          m_a2  <= t_a2;
          h1_v  <= 1'b1;
          h1_a1 <= t_a1;
          h1_a2 <= t_a2;
          m_phase  <= m_phase + incr;
          m_issued <= m_issued + 1;
          if (m_total != 0 && m_issued + 1 == m_total) m_mode <= 2;
        end
        default: if (!h1_v && !h2_v) begin
          m_mode <= 0;
          m_done <= 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("addr1", 32'(rom_bus.addr1), 32'(m_a1));
      check("addr2", 32'(rom_bus.addr2), 32'(m_a2));
      check("valid", 32'(valid), 32'(m_valid));
      check("sample1", 32'(sample1), 32'(m_s1));
      check("sample2", 32'(sample2), 32'(m_s2));
      check("busy", 32'(busy), (m_mode != 0) ? 32'd1 : 32'd0);
      check("done", 32'(done), 32'(m_done));
      if (valid === 1'b1) vcount++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input logic [15:0] i, input logic [7:0] o, input logic [15:0] n);
    incr = i;
    offset = o;
    burst_len = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(done), 32'd1);
    tick();
  endtask

  task automatic test1(input string tag);
    int v0;
    v0 = vcount;
    en = 1'b1;
    begin_burst(16'h0100, 8'd64, 16'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check({tag, "_addr1"}, 32'(rom_bus.addr1), k);
      check({tag, "_addr2"}, 32'(rom_bus.addr2), 64 + k);
    end
    tick();
    tick();
    check({tag, "_last_valid"}, 32'(valid), 32'd1);
    check({tag, "_sample1"}, 32'(sample1), 32'd122);
    check({tag, "_sample2"}, 32'(sample2), 32'd186);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_valids"}, 32'(vcount - v0), 32'd4);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int exp2a[5] = '{0, 0, 1, 1, 2};
    int exp2b[3] = '{0, 255, 254};
    int v0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_addr1", 32'(rom_bus.addr1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sample1", 32'(sample1), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic burst
    test1("t1");

    // 2: fractional step and negative step
    en = 1'b1;
    begin_burst(16'h0080, 8'd0, 16'd5);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_frac_addr1", 32'(rom_bus.addr1), exp2a[k]);
    end
    wait_done("t2_frac_done");
    begin_burst(16'hFF00, 8'd0, 16'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_neg_addr1", 32'(rom_bus.addr1), exp2b[k]);
    end
    wait_done("t2_neg_done");

    // 3: continuous mode with enable gap, then stop
    v0 = vcount;
    en = 1'b1;
    begin_burst(16'h0100, 8'd0, 16'd0);
    tick();
    check("t3_issue0", 32'(rom_bus.addr1), 32'd0);
    en = 1'b0;
    tick();
    check("t3_hold", 32'(rom_bus.addr1), 32'd0);
    en = 1'b1;
    tick();
    check("t3_issue1", 32'(rom_bus.addr1), 32'd1);
    en = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t3_busy_drain", 32'(busy), 32'd1);
    tick();
    check("t3_valid2", 32'(valid), 32'd1);
    check("t3_still_busy", 32'(busy), 32'd1);
    check("t3_no_early_done", 32'(done), 32'd0);
    tick();
    check("t3_done", 32'(done), 32'd1);
    check("t3_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    check("t3_valids", 32'(vcount - v0), 32'd2);

    // 4: offset wrap and accumulator wrap
    en = 1'b1;
    begin_burst(16'h6400, 8'd200, 16'd2);
    tick();
    check("t4_addr2_first", 32'(rom_bus.addr2), 32'd200);
    tick();
    check("t4_addr1", 32'(rom_bus.addr1), 32'd100);
    check("t4_addr2_wrap", 32'(rom_bus.addr2), 32'd44);
    wait_done("t4_done_a");
    begin_burst(16'hFFFF, 8'd0, 16'd3);
    tick();
    check("t4_acc0", 32'(rom_bus.addr1), 32'd0);
    incr = 16'h0001;
    tick();
    check("t4_accFFFF", 32'(rom_bus.addr1), 32'd255);
    tick();
    check("t4_acc_wrap", 32'(rom_bus.addr1), 32'd0);
    wait_done("t4_done_b");

    // 5: start&stop together in IDLE, start ignored while running
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("t5_startstop_busy", 32'(busy), 32'd0);
    tick();
    check("t5_still_idle", 32'(busy), 32'd0);
    en = 1'b1;
    begin_burst(16'h0100, 8'd0, 16'd0);
    repeat (3) tick();
    check("t5_addr2run", 32'(rom_bus.addr1), 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_no_clear", 32'(rom_bus.addr1), 32'd3);
    tick();
    check("t5_continue", 32'(rom_bus.addr1), 32'd4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t5_done");

    // 6: asynchronous reset mid-burst
    en = 1'b1;
    begin_burst(16'h0100, 8'd30, 16'd4);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_addr1", 32'(rom_bus.addr1), 32'd0);
    check("t6_addr2", 32'(rom_bus.addr2), 32'd0);
    check("t6_sample1", 32'(sample1), 32'd0);
    check("t6_sample2", 32'(sample2), 32'd0);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    v0 = vcount;
    repeat (4) begin
      tick();
      check("t6_no_done", 32'(done), 32'd0);
    end
    check("t6_no_valid", 32'(vcount - v0), 32'd0);
    test1("t6_rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
